// File: rtl/czonotope_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : czonotope_stream_tx
// Purpose  : Streams a constrained zonotope (c, G, A, b) out of an element
//            store as a ready/valid beat stream. Fields are read in the
//            order c, G (row-major), A (row-major), b. Empty fields are
//            skipped. A 2-entry output buffer absorbs read latency so the
//            stream sustains one beat per cycle and never loses an element
//            under backpressure.
// Ports    : clk_i, rstn_i       clock, asynchronous active-low reset
//            start_i             start request (IDLE only)
//            n_i, ng_i, nc_i     dimensions, latched on an accepted start
//            rd_en_o, rd_sel_o,  element-store read request
//            rd_row_o, rd_col_o
//            rd_data_i           read data, valid one cycle after rd_en_o
//            m_valid_o, m_ready_i, m_data_o, m_field_o, m_last_o
//                                output beat stream
//            busy_o, done_o      status (done_o is a 1-cycle pulse)
// Revision : 1.0 - initial release
// ============================================================================
module czonotope_stream_tx #(
  parameter int NMAX       = 512,
  parameter int NGMAX      = 512,
  parameter int NCMAX      = 512,
  parameter int DATA_WIDTH = 32,
  localparam int NW   = $clog2(NMAX) + 1,
  localparam int NGW  = $clog2(NGMAX) + 1,
  localparam int NCW  = $clog2(NCMAX) + 1,
  localparam int RMAX = (NMAX > NCMAX) ? NMAX : NCMAX,
  localparam int RW   = $clog2(RMAX),
  localparam int CW   = $clog2(NGMAX)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic [NW-1:0]         n_i,
  input  logic [NGW-1:0]        ng_i,
  input  logic [NCW-1:0]        nc_i,
  output logic                  rd_en_o,
  output logic [1:0]            rd_sel_o,
  output logic [RW-1:0]         rd_row_o,
  output logic [CW-1:0]         rd_col_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic [1:0]            m_field_o,
  output logic                  m_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_C     = 3'd1,
    ST_G     = 3'd2,
    ST_A     = 3'd3,
    ST_B     = 3'd4,
    ST_DRAIN = 3'd5
  } state_e;

  localparam logic [1:0] FLD_C = 2'd0;
  localparam logic [1:0] FLD_G = 2'd1;
  localparam logic [1:0] FLD_A = 2'd2;
  localparam logic [1:0] FLD_B = 2'd3;

  // Control state; row_q/col_q point at the next element to request.
  state_e          state_q;
  logic [NW-1:0]   n_q;
  logic [NGW-1:0]  ng_q;
  logic [NCW-1:0]  nc_q;
  logic [RW-1:0]   row_q;
  logic [CW-1:0]   col_q;

  // Read request stage (drives the store directly).
  logic            rd_en_q;
  logic [1:0]      rd_sel_q;
  logic [RW-1:0]   rd_row_q;
  logic [CW-1:0]   rd_col_q;
  logic            rd_last_q;

  // Arrival stage: tags the data presented on rd_data_i this cycle.
  logic            arr_valid_q;
  logic [1:0]      arr_field_q;
  logic            arr_last_q;

  // 2-entry output buffer.
  logic [DATA_WIDTH-1:0] buf_data_q  [2];
  logic [1:0]            buf_field_q [2];
  logic                  buf_last_q  [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            cnt_q;

  logic            done_q;

  // Combinational helpers.
  logic            is_idle;
  logic [NW-1:0]   n_eff;
  logic [NGW-1:0]  ng_eff;
  logic [NCW-1:0]  nc_eff;
  state_e          pos_state;
  state_e          after_state;
  state_e          nxt_state;
  logic [RW-1:0]   pos_row;
  logic [CW-1:0]   pos_col;
  logic [RW-1:0]   nxt_row;
  logic [CW-1:0]   nxt_col;
  logic [1:0]      pos_sel;
  logic [31:0]     lim_rows;
  logic [31:0]     lim_cols;
  logic            col_end;
  logic            row_end;
  logic            field_end;
  logic            has_buf;
  logic            head_valid;
  logic            pop;
  logic            push;
  logic [1:0]      cnt_d;
  logic            room;
  logic            in_field;
  logic            start_acc;
  logic            issue;
  logic            drain_exit;

  // --------------------------------------------------------------------------
  // Address walk: where the next request points and where it goes after.
  // In IDLE the walk is evaluated from c[0] with the live dimension inputs so
  // the first read can be issued on the very edge that accepts the start.
  // --------------------------------------------------------------------------
  always_comb begin
    is_idle     = (state_q == ST_IDLE);
    n_eff       = is_idle ? n_i  : n_q;
    ng_eff      = is_idle ? ng_i : ng_q;
    nc_eff      = is_idle ? nc_i : nc_q;
    pos_state   = is_idle ? ST_C : state_q;
    pos_row     = is_idle ? '0   : row_q;
    pos_col     = is_idle ? '0   : col_q;

    pos_sel     = FLD_C;
    lim_rows    = 32'(n_eff);
    lim_cols    = 32'd1;
    after_state = ST_DRAIN;
    case (pos_state)
      ST_C: begin
        pos_sel  = FLD_C;
        lim_rows = 32'(n_eff);
        lim_cols = 32'd1;
        if (ng_eff != '0)      after_state = ST_G;
        else if (nc_eff != '0) after_state = ST_B;
        else                   after_state = ST_DRAIN;
      end
      ST_G: begin
        pos_sel     = FLD_G;
        lim_rows    = 32'(n_eff);
        lim_cols    = 32'(ng_eff);
        after_state = (nc_eff != '0) ? ST_A : ST_DRAIN;
      end
      ST_A: begin
        pos_sel     = FLD_A;
        lim_rows    = 32'(nc_eff);
        lim_cols    = 32'(ng_eff);
        after_state = ST_B;
      end
      ST_B: begin
        pos_sel     = FLD_B;
        lim_rows    = 32'(nc_eff);
        lim_cols    = 32'd1;
        after_state = ST_DRAIN;
      end
      default: begin
        pos_sel     = FLD_C;
        after_state = ST_DRAIN;
      end
    endcase

    col_end   = (32'(pos_col) == lim_cols - 32'd1);
    row_end   = (32'(pos_row) == lim_rows - 32'd1);
    field_end = col_end && row_end;

    nxt_state = pos_state;
    nxt_row   = pos_row;
    nxt_col   = pos_col;
    if (field_end) begin
      nxt_state = after_state;
      nxt_row   = '0;
      nxt_col   = '0;
    end else if (col_end) begin
      nxt_row   = pos_row + RW'(1);
      nxt_col   = '0;
    end else begin
      nxt_col   = pos_col + CW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Output buffer bookkeeping and read throttling. When the buffer is empty
  // the arriving word is presented directly; if it is not taken it is
  // captured, so the presented value does not change while stalled.
  // --------------------------------------------------------------------------
  always_comb begin
    has_buf    = (cnt_q != 2'd0);
    head_valid = has_buf || arr_valid_q;
    pop        = head_valid && m_ready_i;
    push       = arr_valid_q && !(pop && !has_buf);
    cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop && has_buf};
    // Next cycle's outstanding = buffered words + the read now on the bus.
    room       = (cnt_d + {1'b0, rd_en_q}) < 2'd2;
    in_field   = (state_q == ST_C) || (state_q == ST_G) ||
                 (state_q == ST_A) || (state_q == ST_B);
    start_acc  = is_idle && start_i;
    issue      = start_acc ? (n_i != '0) : (in_field && room);
    drain_exit = (state_q == ST_DRAIN) && (cnt_d == 2'd0) && !rd_en_q;
  end

  always_comb begin
    m_valid_o = head_valid;
    m_data_o  = '0;
    m_field_o = '0;
    m_last_o  = 1'b0;
    if (head_valid) begin
      m_data_o  = has_buf ? buf_data_q[rd_ptr_q]  : rd_data_i;
      m_field_o = has_buf ? buf_field_q[rd_ptr_q] : arr_field_q;
      m_last_o  = has_buf ? buf_last_q[rd_ptr_q]  : arr_last_q;
    end
  end

  assign rd_en_o  = rd_en_q;
  assign rd_sel_o = rd_sel_q;
  assign rd_row_o = rd_row_q;
  assign rd_col_o = rd_col_q;
  assign busy_o   = (state_q != ST_IDLE);
  assign done_o   = done_q;

  // --------------------------------------------------------------------------
  // Sequential state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q        <= ST_IDLE;
      n_q            <= '0;
      ng_q           <= '0;
      nc_q           <= '0;
      row_q          <= '0;
      col_q          <= '0;
      rd_en_q        <= 1'b0;
      rd_sel_q       <= '0;
      rd_row_q       <= '0;
      rd_col_q       <= '0;
      rd_last_q      <= 1'b0;
      arr_valid_q    <= 1'b0;
      arr_field_q    <= '0;
      arr_last_q     <= 1'b0;
      buf_data_q[0]  <= '0;
      buf_data_q[1]  <= '0;
      buf_field_q[0] <= '0;
      buf_field_q[1] <= '0;
      buf_last_q[0]  <= 1'b0;
      buf_last_q[1]  <= 1'b0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      cnt_q          <= '0;
      done_q         <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      rd_en_q     <= issue;
      arr_valid_q <= rd_en_q;
      arr_field_q <= rd_sel_q;
      arr_last_q  <= rd_last_q;

      if (start_acc) begin
        n_q  <= n_i;
        ng_q <= ng_i;
        nc_q <= nc_i;
        // An empty zonotope completes immediately without any reads.
        if (n_i == '0) done_q <= 1'b1;
      end

      if (issue) begin
        rd_sel_q  <= pos_sel;
        rd_row_q  <= pos_row;
        rd_col_q  <= pos_col;
        rd_last_q <= field_end;
        row_q     <= nxt_row;
        col_q     <= nxt_col;
        state_q   <= nxt_state;
      end

      if (drain_exit) begin
        state_q <= ST_IDLE;
        done_q  <= 1'b1;
      end

      if (push) begin
        buf_data_q[wr_ptr_q]  <= rd_data_i;
        buf_field_q[wr_ptr_q] <= arr_field_q;
        buf_last_q[wr_ptr_q]  <= arr_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop && has_buf) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/czonotope_stream_tx.md
CZONOTOPE_STREAM_TX -- requirements
Module: czonotope_stream_tx

Interface
REQ-001 SHALL have parameter NMAX, default 512, the maximum state dimension n.
REQ-002 SHALL have parameter NGMAX, default 512, the maximum generator count ng.
REQ-003 SHALL have parameter NCMAX, default 512, the maximum constraint count nc.
REQ-004 SHALL have parameter DATA_WIDTH, default 32, the element word width.
REQ-005 SHALL have port clk_i, input, 1 bit: the clock.
REQ-006 SHALL have port rstn_i, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start_i, input, 1 bit: start request, sampled in IDLE only.
REQ-008 SHALL have ports n_i, ng_i, nc_i, inputs, $clog2(NMAX)+1 / $clog2(NGMAX)+1 / $clog2(NCMAX)+1 bits: dimensions, latched on an accepted start.
REQ-009 SHALL have port rd_en_o, output, 1 bit: read strobe to the element store.
REQ-010 SHALL have port rd_sel_o, output, 2 bits: field select, 0=c, 1=G, 2=A, 3=b.
REQ-011 SHALL have ports rd_row_o and rd_col_o, outputs, $clog2(max(NMAX,NCMAX)) / $clog2(NGMAX) bits: element indices.
REQ-012 SHALL have port rd_data_i, input, DATA_WIDTH bits: read data, valid exactly 1 cycle after rd_en_o.
REQ-013 SHALL have ports m_valid_o (output, 1 bit) and m_ready_i (input, 1 bit): the output stream handshake.
REQ-014 SHALL have port m_data_o, output, DATA_WIDTH bits: the element value.
REQ-015 SHALL have port m_field_o, output, 2 bits: the field of the current beat, using the rd_sel_o encoding.
REQ-016 SHALL have port m_last_o, output, 1 bit: marks the final beat of a field.
REQ-017 SHALL have ports busy_o (output, 1 bit, high from an accepted start until done) and done_o (output, 1 bit, 1-cycle pulse).

Function
REQ-018 SHALL accept start_i only in IDLE; start_i while busy_o=1 is ignored.
REQ-019 SHALL use the FSM states IDLE, C, G, A, B and DRAIN.
REQ-020 SHALL issue reads in this order: c[0..n-1] in C; G row-major (row 0..n-1, col 0..ng-1) in G; A row-major (nc x ng) in A; b[0..nc-1] in B.
REQ-021 SHALL skip a field that has zero elements: ng=0 skips G and A; nc=0 skips A and B.
REQ-022 SHALL respond to a start with n_i=0 by pulsing done_o one cycle later, with no beats and no reads.
REQ-023 SHALL drive rd_col_o=0 for the c and b fields.
REQ-024 SHALL move to DRAIN after the final read is issued, then to IDLE once the buffer is empty and the final beat is accepted.
REQ-025 SHALL pulse done_o in the cycle that IDLE is re-entered.
REQ-026 SHALL hold read data in a 2-entry output buffer.
REQ-027 SHALL assert rd_en_o only when the buffered count plus the in-flight read count is less than 2.
REQ-028 SHALL never drop, duplicate or reorder an element.
REQ-029 SHALL transfer a beat when m_valid_o and m_ready_i are both high.
REQ-030 SHALL keep m_data_o, m_field_o and m_last_o stable while m_valid_o=1 and m_ready_i=0.
REQ-031 SHALL assert m_last_o on c[n-1], G[n-1][ng-1], A[nc-1][ng-1] and b[nc-1].
REQ-032 SHALL drive the first m_valid_o 2 cycles after the start is accepted (the start is accepted at edge k, rd_en_o=1 in cycle k+1, m_valid_o=1 in cycle k+2).
REQ-033 SHALL sustain 1 beat per cycle while m_ready_i is held high.
REQ-034 SHALL produce a total beat count of n + n*ng + nc*ng + nc.
REQ-035 SHALL wrap the index counters to 0 at the end of each row and field, with no idle cycle between fields.
REQ-036 SHALL take input changes on n_i, ng_i and nc_i during busy_o=1 with no effect.

Reset
REQ-037 SHALL, when rstn_i=0 (including mid-transfer), go asynchronously to IDLE, flush the buffer and drive every output to 0.
REQ-038 SHALL not pulse done_o for a transfer aborted by reset.
REQ-039 SHALL, after reset release, accept a start on the first clock edge.

Verification
REQ-040 SHALL cover: n=2, ng=3, nc=1, m_ready_i=1 -> 2+6+3+1=12 beats, fields 0,0,1x6,2x3,3, m_last_o on beats 2, 8, 11 and 12, done_o at cycle k+14.
REQ-041 SHALL cover: n=3, ng=2, nc=0 -> 9 beats, no field 2 or 3 beats, m_last_o on beats 3 and 9.
REQ-042 SHALL cover: n=2, ng=2, nc=2 with m_ready_i toggling 1,0,0,1 repeatedly -> 12 beats matching the store contents, stable outputs while stalled, no more than 2 elements outstanding.
REQ-043 SHALL cover: n=0 -> done_o 1 cycle after start, rd_en_o and m_valid_o never asserted.
REQ-044 SHALL cover: rstn_i low for 1 cycle after the 5th beat -> all outputs 0, no done_o, and a new start (n=1, ng=0, nc=0) yields exactly 1 beat with m_last_o=1.
REQ-045 SHALL cover: start_i held high throughout a transfer -> the second transfer begins only after done_o.
